// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, frame length and divider/width helpers.
package uart_pkg;

    localparam int unsigned UART_FRAME_BITS = 10;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_LOCK = 1'b1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Never returns 0 so that single-value counters still get a 1-bit vector.
    function automatic int unsigned uart_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte-stream bundle shared between N_REQ requesters and the TX arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   grant;

    modport master (output req_valid, req_data, req_last, input req_ready, grant);
    modport slave  (input req_valid, req_data, req_last, output req_ready, grant);
endinterface

// File: rtl/uart_tx_ser.sv
// 8N1 serializer, LSB first, DIV clocks per bit; accepts the next byte in the
// final stop-bit cycle so back-to-back frames have no idle gap.
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       busy,
    output logic       tx
);
    localparam int unsigned BW = uart_clog2(DIV);
    localparam int unsigned CW = uart_clog2(UART_FRAME_BITS);

    logic [0:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [CW-1:0] bit_cnt;
    logic [9:0]    shreg;
    logic          bit_end;
    logic          frame_end;

    assign bit_end   = (baud_cnt == BW'(DIV - 1));
    assign frame_end = bit_end && (bit_cnt == CW'(UART_FRAME_BITS - 1));
    assign s_ready   = (state == S_IDLE) || frame_end;
    assign busy      = (state == S_SHIFT);
    assign tx        = (state == S_SHIFT) ? shreg[0] : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '1;
        end else if (s_valid && s_ready) begin
            state    <= S_SHIFT;
            shreg    <= {1'b1, s_data, 1'b0};
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state == S_SHIFT) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (frame_end) begin
                    bit_cnt <= '0;
                    state   <= S_IDLE;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                    shreg   <= {1'b1, shreg[9:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX pin among N_REQ requesters.
// Optional stalled-lock timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned CLK_HZ      = 16000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave req,
    output logic             busy,
    output logic             uart_tx
);
    localparam int unsigned DIV = uart_div(CLK_HZ, BAUD);
    localparam int unsigned PW  = uart_clog2(N_REQ);

    if (N_REQ < 1 || N_REQ > 8) begin : g_bad_nreq
        $error("uart_tx_arbiter: N_REQ must be 1..8");
    end
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_arbiter: CLK_HZ/BAUD must be >= 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYC must be >= 1");
    end

    logic [0:0]       state;
    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    next_ptr;
    logic [N_REQ-1:0] pick_oh;
    logic             pick_found;
    logic             owner_valid;
    logic             owner_last;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_ready;
    logic             accept;
    logic             timeout_hit;

    assign req.grant     = grant;
    assign req.req_ready = grant & {N_REQ{s_ready}};

    always_comb begin
        owner  = '0;
        s_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                owner  = PW'(i);
                s_data = req.req_data[8*i +: 8];
            end
        end
    end

    assign owner_valid = |(grant & req.req_valid);
    assign owner_last  = |(grant & req.req_last);
    assign s_valid     = owner_valid;
    assign accept      = s_valid && s_ready;
    assign next_ptr    = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_oh    = '0;
        pick_found = 1'b0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = (int'(rr_ptr) + off) % N_REQ;
            if (!pick_found && req.req_valid[PW'(idx)]) begin
                pick_found          = 1'b1;
                pick_oh[PW'(idx)]   = 1'b1;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned TW = uart_clog2(TIMEOUT_CYC);
    logic [TW-1:0] to_cnt;

    assign timeout_hit = (state == ARB_LOCK) && !owner_valid && (to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || state != ARB_LOCK || owner_valid || timeout_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TW'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant <= pick_oh;
                        state <= ARB_LOCK;
                    end
                end
                ARB_LOCK: begin
                    if ((accept && owner_last) || timeout_hit) begin
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                        state  <= ARB_IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    uart_tx_ser #(
        .DIV(DIV)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .busy    (busy),
        .tx      (uart_tx)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (DIV=4): a line monitor decodes frames and
// compares them against bytes queued in the order the arbiter must emit them.
module tb_uart_tx_arbiter;
    localparam int N_REQ     = 2;
    localparam int DIV       = 4;
    localparam int FRAME_CYC = 10 * DIV;
    localparam int TIMEOUT   = 4096;

    typedef struct {
        logic [7:0] data;
        bit         contig;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic uart_tx;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   frames = 0;
    exp_t sb[$];

    uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

    uart_tx_arbiter #(
        .N_REQ       (N_REQ),
        .CLK_HZ      (4),
        .BAUD        (1),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (bus),
        .busy    (busy),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic expect_byte(input logic [7:0] d, input bit contig);
        exp_t e;
        e.data   = d;
        e.contig = contig;
        sb.push_back(e);
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic l, input int budget);
        bit ok;
        ok = 1'b0;
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = d;
        bus.req_last[i]        = l;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        bus.req_valid[i] = 1'b0;
        bus.req_last[i]  = 1'b0;
        check($sformatf("accept_req%0d_%0h", i, d), 32'(ok), 1);
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain", sb.size(), 0);
    endtask

    // Line monitor: bit k sampled mid-bit at offset k*DIV + DIV/2 from start detection.
    bit       mon_active = 1'b0;
    int       mon_cnt = 0;
    int       mon_start = 0;
    int       prev_start = 0;
    bit [9:0] mon_bits;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (uart_tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_start  = cyc;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % DIV == DIV / 2) mon_bits[mon_cnt / DIV] = uart_tx;
            if (mon_cnt == FRAME_CYC - 1) begin
                bit   have_exp;
                exp_t e;
                mon_active = 1'b0;
                frames++;
                check("frame_start_bit", 32'(mon_bits[0]), 0);
                check("frame_stop_bit", 32'(mon_bits[9]), 1);
                have_exp = (sb.size() != 0);
                check("frame_expected", 32'(have_exp), 1);
                if (have_exp) begin
                    e = sb.pop_front();
                    check("frame_data", 32'(mon_bits[8:1]), 32'(e.data));
                    if (e.contig) check("frame_gap", mon_start - prev_start, FRAME_CYC);
                end
                prev_start = mon_start;
            end
        end
    end

    initial begin
        logic [9:0] seq;
        int         n_grant;
        int         frames_before;

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_uart_tx", 32'(uart_tx), 1);
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single byte 0xA5 from Req0: exact line waveform
        seq = 10'b1101001010;
        expect_byte(8'hA5, 1'b0);
        send(0, 8'hA5, 1'b1, 100);
        for (int k = 0; k < FRAME_CYC; k++) begin
            @(negedge clk);
            check($sformatf("a5_tx_c%0d", k), 32'(uart_tx), 32'(seq[k / DIV]));
            if (k == 0) begin
                check("a5_grant_released", 32'(bus.grant), 0);
                check("a5_busy_first", 32'(busy), 1);
            end
            if (k == FRAME_CYC - 1) check("a5_busy_last", 32'(busy), 1);
        end
        @(negedge clk);
        check("a5_busy_after", 32'(busy), 0);
        check("a5_tx_idle", 32'(uart_tx), 1);
        drain(100);

        // Reset mid-frame drops the byte and idles the line
        send(0, 8'hFF, 1'b1, 100);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        frames_before = frames;
        @(posedge clk);
        @(negedge clk);
        check("midrst_uart_tx", 32'(uart_tx), 1);
        check("midrst_grant", 32'(bus.grant), 0);
        check("midrst_req_ready", 32'(bus.req_ready), 0);
        check("midrst_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (60) @(negedge clk);
        check("midrst_no_frame", frames - frames_before, 0);
        check("midrst_line_idle", 32'(uart_tx), 1);
        @(posedge clk);
        #1;

        // Both valid out of reset: Req0 first, one unowned cycle, then Req1
        expect_byte(8'hB1, 1'b0);
        expect_byte(8'hB2, 1'b1);
        fork
            send(1, 8'hB2, 1'b1, 400);
            begin
                @(negedge clk);
                check("t3_grant_registered", 32'(bus.grant), 0);
                @(negedge clk);
                check("t3_grant_req0", 32'(bus.grant), 2'b01);
            end
        join_none
        send(0, 8'hB1, 1'b1, 400);
        @(negedge clk);
        check("t3_unowned_cycle", 32'(bus.grant), 0);
        @(negedge clk);
        check("t3_grant_req1", 32'(bus.grant), 2'b10);
        wait fork;
        drain(200);

        // Req1 3-byte packet while Req0 waits
        expect_byte(8'h01, 1'b0);
        expect_byte(8'h02, 1'b1);
        expect_byte(8'h03, 1'b1);
        expect_byte(8'h5A, 1'b0);
        @(posedge clk);
        #1 bus.req_valid[1] = 1'b1;
        bus.req_data[15:8]  = 8'h01;
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b1;
        bus.req_data[7:0]   = 8'h5A;
        bus.req_last[0]     = 1'b1;
        check("t4_grant_req1", 32'(bus.grant), 2'b10);
        send(1, 8'h01, 1'b0, 200);
        check("t4_req0_blocked_1", 32'(bus.req_ready[0]), 0);
        send(1, 8'h02, 1'b0, 200);
        check("t4_req0_blocked_2", 32'(bus.req_ready[0]), 0);
        send(1, 8'h03, 1'b1, 200);
        @(negedge clk);
        check("t4_unowned_cycle", 32'(bus.grant), 0);
        @(negedge clk);
        check("t4_grant_req0", 32'(bus.grant), 2'b01);
        send(0, 8'h5A, 1'b1, 200);
        drain(300);

        // Req0 two single-byte packets with Req1 idle
        expect_byte(8'h3C, 1'b0);
        expect_byte(8'hC3, 1'b0);
        send(0, 8'h3C, 1'b1, 200);
        @(negedge clk);
        check("t6_release_1", 32'(bus.grant), 0);
        send(0, 8'hC3, 1'b1, 200);
        @(negedge clk);
        check("t6_release_2", 32'(bus.grant), 0);
        drain(200);

        // Req0 stalls mid-packet while Req1 waits
        expect_byte(8'h11, 1'b0);
`ifdef UART_ARB_TIMEOUT_EN
        expect_byte(8'h33, 1'b0);
        expect_byte(8'h22, 1'b0);
`else
        expect_byte(8'h22, 1'b0);
        expect_byte(8'h33, 1'b0);
`endif
        send(0, 8'h11, 1'b0, 200);
        n_grant = 0;
        fork
            send(1, 8'h33, 1'b1, 6000);
        join_none
        for (int n = 1; n <= 5000; n++) begin
            @(negedge clk);
            if (bus.grant[1]) begin
                n_grant = n;
                break;
            end
        end
`ifdef UART_ARB_TIMEOUT_EN
        check("t5_timeout_window", 32'(n_grant >= TIMEOUT && n_grant <= TIMEOUT + 4), 1);
        wait fork;
        send(0, 8'h22, 1'b1, 400);
`else
        check("t5_lock_held", n_grant, 0);
        check("t5_grant_req0", 32'(bus.grant), 2'b01);
        check("t5_req1_not_ready", 32'(bus.req_ready[1]), 0);
        send(0, 8'h22, 1'b1, 400);
        wait fork;
`endif
        drain(300);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
